// File: rtl/pwm_dac_tx.sv
// pwm_dac_tx: fixed-period PWM generator. Each period is 2^WIDTH ticks. A new
// duty code arrives over a valid/ready handshake, is held in a pending buffer,
// and is copied into the active duty only at a period boundary. While the
// block is disabled, a pending code is copied at once instead.
module pwm_dac_tx #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_start
);

  // The prescaler needs at least one bit, even when PRESCALE=1 and it stays 0.
  localparam int               PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic             pend_q, pend_d;
  logic             pwm_q, pwm_d;
  logic             ps_q, ps_d;

  logic tick, boundary, xfer;

  // Timebase: the prescaler sets the tick rate, and ticks advance the period counter.
  always_comb begin
    tick     = enable && (presc_q == PRESC_MAX);
    boundary = tick && (cnt_q == CNT_MAX);
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    if (!enable) begin
      presc_d = '0;
      cnt_d   = '0;
    end else begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
      if (tick) cnt_d = cnt_q + 1'b1;
    end
  end

  // Double buffer. A pending code is applied at a boundary, or at once while
  // disabled. A transfer can only occur when nothing is pending, so a code
  // captured in a boundary cycle waits for the following boundary.
  always_comb begin
    xfer        = duty_valid && !pend_q;
    active_d    = active_q;
    pend_duty_d = pend_duty_q;
    pend_d      = pend_q;
    if (pend_q && (!enable || boundary)) begin
      active_d = pend_duty_q;
      pend_d   = 1'b0;
    end else if (xfer) begin
      pend_duty_d = duty_in;
      pend_d      = 1'b1;
    end
  end

  // Output decode, registered one cycle behind the counter state.
  always_comb begin
    pwm_d = enable && (cnt_q < active_q);
    ps_d  = enable && (cnt_q == '0) && (presc_q == '0);
  end

  // State registers, with all state cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      cnt_q       <= '0;
      active_q    <= '0;
      pend_duty_q <= '0;
      pend_q      <= 1'b0;
      pwm_q       <= 1'b0;
      ps_q        <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pend_duty_q <= pend_duty_d;
      pend_q      <= pend_d;
      pwm_q       <= pwm_d;
      ps_q        <= ps_d;
    end
  end

  assign duty_ready   = !pend_q;
  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule

// File: doc/pwm_dac_tx.md
Name: pwm_dac_tx

Overview:
- Digital-to-PWM transmitter; the output-direction counterpart of the PWM ADC front end.
- Accepts a WIDTH-bit duty code through a valid/ready handshake and produces a fixed-period PWM waveform on pwm_out.
- Duty updates are double-buffered and take effect only at a period boundary, so no glitch or partial period is ever emitted.
- Drives the analog filter / transducer path; the bench loops pwm_out back into the PWM ADC.

Parameters:
- WIDTH, 8: duty code and period counter width; period is 2^WIDTH ticks.
- PRESCALE, 1: clk cycles per counter tick; legal range is 1 or more.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  run/stop for the generator.
- duty_in  input  WIDTH  new duty code; high time per period is duty_in ticks.
- duty_valid  input  1  duty_in is valid.
- duty_ready  output  1  block can accept a code.
- pwm_out  output  1  PWM waveform, registered.
- period_start  output  1  one-clk pulse, aligned with the first pwm_out cycle of each period.

Behaviour:
- Reset (async assert, sync-safe deassert): prescaler=0, cnt=0, active_duty=0, pending_duty=0, pending=0, pwm_out=0, period_start=0, duty_ready=1.
- Reset mid-operation abandons the current period and any pending code immediately.
- Prescaler:
  - presc counts 0..PRESCALE-1; tick=1 when presc==PRESCALE-1 and enable=1.
  - With PRESCALE=1, tick=enable every cycle.
- Period counter:
  - On tick, cnt increments modulo 2^WIDTH.
  - Boundary = tick and cnt==2^WIDTH-1. At the boundary, cnt wraps to 0. If pending=1, active_duty<=pending_duty and pending<=0.
- Handshake:
  - duty_ready = !pending.
  - Transfer occurs when duty_valid and duty_ready are both high: pending_duty<=duty_in, pending<=1.
  - A transfer in the same cycle as a boundary is captured into pending only. It applies at the next boundary, not this one.
  - While duty_ready=0, the source holds duty_in/duty_valid. The block ignores them with no capture.
  - After a boundary consumes pending, duty_ready returns to 1 on the following cycle.
- Output (registered, 1-cycle latency):
  - pwm_out(t+1) = enable(t) && (cnt(t) < active_duty(t)), unsigned compare.
  - period_start(t+1) = enable(t) && cnt(t)==0 && presc(t)==0.
- Duty extremes:
  - Code 0 gives pwm_out constantly 0.
  - Code 2^WIDTH-1 gives high for 2^WIDTH-1 ticks and low for 1 tick.
  - 100% duty is not representable; this is intentional.
- enable=0:
  - presc and cnt are forced to 0. pwm_out=0 and period_start=0 from the next cycle.
  - Any pending code loads into active_duty immediately (next cycle) and pending clears. The handshake remains live.
- enable 0→1: counting starts at cnt=0. The first period_start appears the cycle after enable is sampled high.
- No other state.
- Target implementation size: 120-250 lines RTL.

Test Plan:
All cases use WIDTH=8 unless stated.
- PRESCALE=1, rst_n released, enable=1, write duty 16 → after the first boundary, each 256-cycle period has pwm_out high exactly 16 clk then low 240. period_start repeats every 256 clk.
- Write duty 0, then duty 255 in consecutive periods → one period with pwm_out all low, then a period high 255 and low 1. No extra edges at the transitions.
- Write duty 64, then duty 200 presented in the boundary cycle → the 200 is accepted but the next period is still 64. The following period is 200. duty_ready stays low for exactly the cycles pending=1.
- Hold duty_valid with values 10 then 20 while duty_ready=0 → only the first accepted code (10) appears. 20 is accepted only after duty_ready rises, and applies one period later.
- PRESCALE=4, duty 3 → period is 1024 clk with high time 12 clk. enable dropped mid-high: pwm_out low the next cycle, cnt=0. Re-enable: period_start one cycle later and a full 12-clk high.
- Assert rst_n low mid-period with pwm_out=1 → pwm_out, period_start and pending all 0 asynchronously, and duty_ready=1. After release with enable=1, pwm_out stays low because active_duty=0.
